// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select or round-robin auto scan.
// One output word slot (EMPTY/FULL) with valid/ready handshake and per-channel ack.
module mux_scan_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ack,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned PadW = 1 << SEL_W;
  localparam logic [SEL_W:0] ChanCnt = (SEL_W + 1)'(CHANNELS);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e r_state;
  state_e w_state_next;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic                  w_can_load;
  logic [PadW-1:0]       w_valid_pad;
  logic                  w_man_ok;
  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic                  w_auto_ok;
  logic [SEL_W-1:0]      w_auto_off;
  logic [SEL_W:0]        w_sum;
  logic [SEL_W-1:0]      w_auto_k;
  logic [SEL_W-1:0]      w_ptr_next;
  logic                  w_load;
  logic [SEL_W-1:0]      w_k;
  logic [WIDTH-1:0]      w_word;
  logic [CHANNELS-1:0]   w_ack;

  assign w_can_load = (r_state == StEmpty) || out_ready;

  // Zero-padded so an out-of-range select reads a 0 instead of X.
  assign w_valid_pad = PadW'(in_valid);
  assign w_man_ok    = ({1'b0, select} < ChanCnt) && w_valid_pad[select];

  // Rotate valids so bit 0 is the channel at ptr, then find the lowest set bit.
  assign w_dbl = {in_valid, in_valid};
  assign w_rot = CHANNELS'(w_dbl >> r_ptr);

  always_comb begin
    w_auto_ok  = 1'b0;
    w_auto_off = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_auto_ok  = 1'b1;
        w_auto_off = SEL_W'(i);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_auto_off};
  assign w_auto_k   = (w_sum >= ChanCnt) ? SEL_W'(w_sum - ChanCnt) : SEL_W'(w_sum);
  assign w_ptr_next = (w_auto_k == SEL_W'(CHANNELS - 1)) ? '0 : w_auto_k + SEL_W'(1);

  assign w_load = w_can_load && (mode ? w_auto_ok : w_man_ok);
  assign w_k    = mode ? w_auto_k : select;

  always_comb begin
    w_word = '0;
    w_ack  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_k == SEL_W'(k)) begin
        w_word   = in_data[k*WIDTH +: WIDTH];
        w_ack[k] = w_load && rst_n;
      end
    end
  end

  assign in_ack = w_ack;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StEmpty: if (w_load) w_state_next = StFull;
      StFull:  if (out_ready) w_state_next = w_load ? StFull : StEmpty;
      default: w_state_next = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_data <= w_word;
        r_chan <= w_k;
      end
      if (w_load && mode) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = (r_state == StFull);

endmodule
